// File: rtl/stall_sequencer.sv
// stall_sequencer: pipeline stall control for syscall / LL/SC-flush service.
// Freezes fetch, drains DRAIN_CYCLES bubbles into EXE, then requests service
// from the simulator and waits for its acknowledge before releasing the pipe.
// Optional watchdog on the service wait is enabled by defining the macro
// STALL_SEQ_TIMEOUT_EN; without it SERVICE waits indefinitely.
module stall_sequencer #(
    parameter int unsigned DRAIN_CYCLES   = 3,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        SYSCALL_IN,
    input  logic        LLSC_IN,
    input  logic        MEM_FREEZE_IN,
    input  logic        SIM_ACK_IN,
    output logic        FREEZE_IF_OUT,
    output logic        FREEZE_ID_OUT,
    output logic        BUBBLE_ID_OUT,
    output logic        SYS_OUT,
    output logic [15:0] SYSCALL_COUNT_OUT,
    output logic        TIMEOUT_ERR_OUT
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_DRAIN   = 2'd1;
    localparam logic [1:0] ST_SERVICE = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    // Drain counter counts down to zero, so the last drain cycle sees 0.
    localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_CYCLES - 1);

    logic [1:0]  state_q, state_d;
    logic [2:0]  drain_cnt_q, drain_cnt_d;
    logic        llsc_q, llsc_d;
    logic [15:0] sys_cnt_q, sys_cnt_d;
    logic        wdog_expire;

    logic in_idle, in_drain, in_service;
    assign in_idle    = (state_q == ST_IDLE);
    assign in_drain   = (state_q == ST_DRAIN);
    assign in_service = (state_q == ST_SERVICE);

`ifdef STALL_SEQ_TIMEOUT_EN
    localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] wdog_q, wdog_d;
    logic       err_q, err_d;

    // Expiry only counts as an error when nothing else is ending the service.
    assign wdog_expire = in_service && (wdog_q == WDOG_LAST) && !SIM_ACK_IN && !llsc_q;

    // Watchdog counts unfrozen SERVICE cycles; cleared in every other state.
    always_comb begin
        wdog_d = wdog_q;
        err_d  = err_q;
        if (!MEM_FREEZE_IN) begin
            if (in_service) begin
                wdog_d = wdog_q + 8'd1;
                if (wdog_expire) err_d = 1'b1;
            end else begin
                wdog_d = 8'd0;
            end
        end
    end

    // Watchdog and sticky error registers.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wdog_q <= 8'd0;
            err_q  <= 1'b0;
        end else begin
            wdog_q <= wdog_d;
            err_q  <= err_d;
        end
    end

    assign TIMEOUT_ERR_OUT = err_q;
`else
    assign wdog_expire     = 1'b0;
    assign TIMEOUT_ERR_OUT = 1'b0;
`endif

    // Next-state logic; a MEM freeze holds everything in place.
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        llsc_d      = llsc_q;
        sys_cnt_d   = sys_cnt_q;
        if (!MEM_FREEZE_IN) begin
            case (state_q)
                ST_IDLE: begin
                    if (SYSCALL_IN) begin
                        state_d     = ST_DRAIN;
                        drain_cnt_d = DRAIN_LOAD;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt_q == 3'd0) begin
                        state_d = ST_SERVICE;
                        llsc_d  = LLSC_IN;
                    end else begin
                        drain_cnt_d = drain_cnt_q - 3'd1;
                    end
                end
                ST_SERVICE: begin
                    // LL/SC flushes need no simulator, so they leave at once.
                    if (SIM_ACK_IN || llsc_q || wdog_expire) begin
                        state_d   = ST_RELEASE;
                        sys_cnt_d = sys_cnt_q + 16'd1;
                    end
                end
                ST_RELEASE: begin
                    // One cycle for ID to advance past the serviced syscall.
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State, drain counter, LL/SC latch and service counter registers.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= ST_IDLE;
            drain_cnt_q <= 3'd0;
            llsc_q      <= 1'b0;
            sys_cnt_q   <= 16'd0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            llsc_q      <= llsc_d;
            sys_cnt_q   <= sys_cnt_d;
        end
    end

    assign FREEZE_IF_OUT     = MEM_FREEZE_IN | (in_idle & SYSCALL_IN) | in_drain | in_service;
    assign FREEZE_ID_OUT     = MEM_FREEZE_IN | in_drain | in_service;
    assign BUBBLE_ID_OUT     = in_drain | in_service;
    assign SYS_OUT           = in_service & ~llsc_q;
    assign SYSCALL_COUNT_OUT = sys_cnt_q;

endmodule

// File: tb/tb_stall_sequencer.sv
// Self-checking bench for stall_sequencer: directed scenarios plus a random
// run against a transaction-level reference model.
module tb_stall_sequencer;

    localparam int DRAIN   = 3;
    localparam int TIMEOUT = 8;
`ifdef STALL_SEQ_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        SYSCALL_IN = 1'b0, LLSC_IN = 1'b0, MEM_FREEZE_IN = 1'b0, SIM_ACK_IN = 1'b0;
    logic        FREEZE_IF_OUT, FREEZE_ID_OUT, BUBBLE_ID_OUT, SYS_OUT, TIMEOUT_ERR_OUT;
    logic [15:0] SYSCALL_COUNT_OUT;

    int checks = 0;
    int failures = 0;

    stall_sequencer #(.DRAIN_CYCLES(DRAIN), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .CLK(CLK), .RESET(RESET), .SYSCALL_IN(SYSCALL_IN), .LLSC_IN(LLSC_IN),
        .MEM_FREEZE_IN(MEM_FREEZE_IN), .SIM_ACK_IN(SIM_ACK_IN),
        .FREEZE_IF_OUT(FREEZE_IF_OUT), .FREEZE_ID_OUT(FREEZE_ID_OUT),
        .BUBBLE_ID_OUT(BUBBLE_ID_OUT), .SYS_OUT(SYS_OUT),
        .SYSCALL_COUNT_OUT(SYSCALL_COUNT_OUT), .TIMEOUT_ERR_OUT(TIMEOUT_ERR_OUT)
    );

    always #5 CLK = ~CLK;

    // Reference model: a syscall is tracked as bubbles still owed, an open
    // service window, and a one-cycle release gap.
    int          m_drain_left;
    bit          m_svc, m_rel, m_ll, m_err;
    int          m_wd;
    logic [15:0] m_cnt;
    logic        m_to;
    assign m_to = TO_EN && m_svc && (m_wd + 1 >= TIMEOUT) && !SIM_ACK_IN && !m_ll;

    always @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            m_drain_left <= 0; m_svc <= 0; m_rel <= 0; m_ll <= 0;
            m_wd <= 0; m_cnt <= 16'd0; m_err <= 0;
        end else if (!MEM_FREEZE_IN) begin
            if (m_drain_left > 0) begin
                m_drain_left <= m_drain_left - 1;
                if (m_drain_left == 1) begin
                    m_svc <= 1; m_ll <= LLSC_IN; m_wd <= 0;
                end
            end else if (m_svc) begin
                if (SIM_ACK_IN || m_ll || m_to) begin
                    m_svc <= 0; m_rel <= 1; m_cnt <= m_cnt + 16'd1;
                    if (m_to) m_err <= 1;
                end else begin
                    m_wd <= m_wd + 1;
                end
            end else if (m_rel) begin
                m_rel <= 0;
            end else if (SYSCALL_IN) begin
                m_drain_left <= DRAIN;
            end
        end
    end

    logic m_busy, m_idle;
    logic [20:0] exp_vec, got_vec;
    assign m_busy  = (m_drain_left > 0) || m_svc;
    assign m_idle  = !m_busy && !m_rel;
    assign exp_vec = {MEM_FREEZE_IN | (m_idle & SYSCALL_IN) | m_busy, MEM_FREEZE_IN | m_busy,
                      m_busy, m_svc & ~m_ll, m_cnt, m_err};
    assign got_vec = {FREEZE_IF_OUT, FREEZE_ID_OUT, BUBBLE_ID_OUT, SYS_OUT,
                      SYSCALL_COUNT_OUT, TIMEOUT_ERR_OUT};

    // Advance one clock, then apply this cycle's inputs; outputs settle by return.
    task automatic tick(input bit sc, input bit ll, input bit mf, input bit ack);
        @(posedge CLK); #1;
        SYSCALL_IN = sc; LLSC_IN = ll; MEM_FREEZE_IN = mf; SIM_ACK_IN = ack;
        #1;
    endtask

    task automatic do_reset();
        SYSCALL_IN = 0; LLSC_IN = 0; MEM_FREEZE_IN = 0; SIM_ACK_IN = 0;
        RESET = 0;
        repeat (2) @(negedge CLK);
        RESET = 1;
    endtask

    task automatic test_reset();
        #3;
        checks++; if (FREEZE_IF_OUT !== 1'b0) begin failures++; $display("FAIL reset_freeze_if got=%b exp=0", FREEZE_IF_OUT); end
        checks++; if (FREEZE_ID_OUT !== 1'b0) begin failures++; $display("FAIL reset_freeze_id got=%b exp=0", FREEZE_ID_OUT); end
        checks++; if (BUBBLE_ID_OUT !== 1'b0) begin failures++; $display("FAIL reset_bubble got=%b exp=0", BUBBLE_ID_OUT); end
        checks++; if (SYS_OUT !== 1'b0) begin failures++; $display("FAIL reset_sys got=%b exp=0", SYS_OUT); end
        checks++; if (SYSCALL_COUNT_OUT !== 16'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", SYSCALL_COUNT_OUT); end
        checks++; if (TIMEOUT_ERR_OUT !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", TIMEOUT_ERR_OUT); end
        @(negedge CLK); RESET = 1;
    endtask

    // Plain syscall, ack on the second SYS_OUT cycle.
    task automatic test_basic_syscall();
        int bub = 0, sys = 0, ack_at = -1;
        do_reset();
        tick(1, 0, 0, 0);
        checks++; if (FREEZE_IF_OUT !== 1'b1 || BUBBLE_ID_OUT !== 1'b0) begin
            failures++; $display("FAIL basic_accept got_if=%b got_bub=%b exp_if=1 exp_bub=0", FREEZE_IF_OUT, BUBBLE_ID_OUT);
        end
        for (int i = 0; i < 12; i++) begin
            tick(0, 0, 0, 0);
            if (BUBBLE_ID_OUT) bub++;
            if (SYS_OUT) begin
                sys++;
                if (sys == 2) begin SIM_ACK_IN = 1; ack_at = i; end
            end
        end
        checks++; if (bub != 5) begin failures++; $display("FAIL basic_bubbles got=%0d exp=5", bub); end
        checks++; if (sys != 2) begin failures++; $display("FAIL basic_sys_cycles got=%0d exp=2", sys); end
        checks++; if (ack_at != 4) begin failures++; $display("FAIL basic_ack_cycle got=%0d exp=4", ack_at); end
        checks++; if (SYSCALL_COUNT_OUT !== 16'd1) begin failures++; $display("FAIL basic_count got=%0d exp=1", SYSCALL_COUNT_OUT); end
    endtask

    // LL/SC flush: no simulator request, one-cycle service.
    task automatic test_llsc();
        int bub = 0, sys = 0;
        do_reset();
        tick(1, 1, 0, 0);
        for (int i = 0; i < 10; i++) begin
            tick(0, 1, 0, 0);
            if (BUBBLE_ID_OUT) bub++;
            if (SYS_OUT) sys++;
        end
        checks++; if (sys != 0) begin failures++; $display("FAIL llsc_sys_cycles got=%0d exp=0", sys); end
        checks++; if (bub != DRAIN + 1) begin failures++; $display("FAIL llsc_bubbles got=%0d exp=%0d", bub, DRAIN + 1); end
        checks++; if (SYSCALL_COUNT_OUT !== 16'd1) begin failures++; $display("FAIL llsc_count got=%0d exp=1", SYSCALL_COUNT_OUT); end
    endtask

    // MEM freeze for 4 cycles inside DRAIN stretches the bubble train by 4.
    task automatic test_freeze_mid_drain();
        int bub = 0; bit acked = 0, mf;
        do_reset();
        tick(1, 0, 0, 0);
        for (int i = 0; i < 14; i++) begin
            mf = (i >= 1 && i <= 4);
            tick(0, 0, mf, 0);
            if (BUBBLE_ID_OUT) begin
                bub++;
                checks++; if (FREEZE_ID_OUT !== 1'b1) begin
                    failures++; $display("FAIL freeze_id_held cyc=%0d got=%b exp=1", i, FREEZE_ID_OUT);
                end
            end
            if (SYS_OUT && !acked) begin SIM_ACK_IN = 1; acked = 1; end
        end
        checks++; if (bub != DRAIN + 4 + 1) begin failures++; $display("FAIL freeze_bubbles got=%0d exp=%0d", bub, DRAIN + 5); end
        checks++; if (SYSCALL_COUNT_OUT !== 16'd1) begin failures++; $display("FAIL freeze_count got=%0d exp=1", SYSCALL_COUNT_OUT); end
    endtask

    // Reset asserted mid-SERVICE clears everything immediately.
    task automatic test_reset_mid_service();
        bit done = 0;
        do_reset();
        tick(1, 0, 0, 0);
        for (int i = 0; i < 20 && !done; i++) begin
            tick(0, 0, 0, 1);
            if (!BUBBLE_ID_OUT && i > DRAIN) done = 1;
        end
        checks++; if (SYSCALL_COUNT_OUT !== 16'd1) begin failures++; $display("FAIL rst_pre_count got=%0d exp=1", SYSCALL_COUNT_OUT); end
        tick(1, 0, 0, 0);
        repeat (DRAIN + 1) tick(0, 0, 0, 0);
        checks++; if (SYS_OUT !== 1'b1) begin failures++; $display("FAIL rst_in_service got=%b exp=1", SYS_OUT); end
        #1 RESET = 0;
        #1;
        checks++; if (got_vec !== 21'd0) begin failures++; $display("FAIL rst_async_clear got=%h exp=0", got_vec); end
        @(negedge CLK); @(negedge CLK);
        checks++; if (got_vec !== 21'd0) begin failures++; $display("FAIL rst_held_clear got=%h exp=0", got_vec); end
        RESET = 1;
        tick(1, 0, 0, 0);
        tick(0, 0, 0, 0);
        checks++; if (BUBBLE_ID_OUT !== 1'b1) begin failures++; $display("FAIL rst_first_accept got=%b exp=1", BUBBLE_ID_OUT); end
    endtask

    // SYSCALL_IN held high through RELEASE: one service, then a fresh DRAIN.
    task automatic test_back_to_back();
        int sys = 0; bit acked = 0;
        do_reset();
        tick(1, 0, 0, 0);
        for (int i = 0; i < 7; i++) begin
            tick(1, 0, 0, 0);
            if (SYS_OUT) sys++;
            if (SYS_OUT && !acked) begin SIM_ACK_IN = 1; acked = 1; end
            if (i == DRAIN + 1) begin
                checks++; if (FREEZE_IF_OUT !== 1'b0 || BUBBLE_ID_OUT !== 1'b0) begin
                    failures++; $display("FAIL b2b_release got_if=%b got_bub=%b exp=0/0", FREEZE_IF_OUT, BUBBLE_ID_OUT);
                end
                checks++; if (SYSCALL_COUNT_OUT !== 16'd1) begin failures++; $display("FAIL b2b_count got=%0d exp=1", SYSCALL_COUNT_OUT); end
            end
            if (i == DRAIN + 2) begin
                checks++; if (FREEZE_IF_OUT !== 1'b1 || BUBBLE_ID_OUT !== 1'b0) begin
                    failures++; $display("FAIL b2b_idle got_if=%b got_bub=%b exp=1/0", FREEZE_IF_OUT, BUBBLE_ID_OUT);
                end
            end
            if (i == DRAIN + 3) begin
                checks++; if (BUBBLE_ID_OUT !== 1'b1) begin failures++; $display("FAIL b2b_new_drain got=%b exp=1", BUBBLE_ID_OUT); end
            end
        end
        checks++; if (sys != 1) begin failures++; $display("FAIL b2b_services got=%0d exp=1", sys); end
    endtask

    // SYSCALL_IN during MEM freeze is deferred; stray acks are ignored.
    task automatic test_idle_defer();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            tick(1, 0, 1, 1);
            checks++; if ({FREEZE_IF_OUT, FREEZE_ID_OUT, BUBBLE_ID_OUT, SYS_OUT} !== 4'b1100) begin
                failures++; $display("FAIL defer_hold cyc=%0d got=%b exp=1100", i, {FREEZE_IF_OUT, FREEZE_ID_OUT, BUBBLE_ID_OUT, SYS_OUT});
            end
        end
        tick(1, 0, 0, 1);
        checks++; if (BUBBLE_ID_OUT !== 1'b0) begin failures++; $display("FAIL defer_release got=%b exp=0", BUBBLE_ID_OUT); end
        tick(0, 0, 0, 1);
        checks++; if (BUBBLE_ID_OUT !== 1'b1) begin failures++; $display("FAIL defer_drain got=%b exp=1", BUBBLE_ID_OUT); end
        checks++; if (SYSCALL_COUNT_OUT !== 16'd0) begin failures++; $display("FAIL defer_count got=%0d exp=0", SYSCALL_COUNT_OUT); end
    endtask

    // Watchdog behaviour (or its absence) with no simulator acknowledge.
    task automatic test_watchdog();
        int sys = 0;
        do_reset();
        tick(1, 0, 0, 0);
`ifdef STALL_SEQ_TIMEOUT_EN
        for (int i = 0; i < 20; i++) begin
            tick(0, 0, 0, 0);
            if (SYS_OUT) sys++;
        end
        checks++; if (sys != TIMEOUT) begin failures++; $display("FAIL wdog_service_len got=%0d exp=%0d", sys, TIMEOUT); end
        checks++; if (TIMEOUT_ERR_OUT !== 1'b1) begin failures++; $display("FAIL wdog_err got=%b exp=1", TIMEOUT_ERR_OUT); end
        checks++; if (SYSCALL_COUNT_OUT !== 16'd1) begin failures++; $display("FAIL wdog_count got=%0d exp=1", SYSCALL_COUNT_OUT); end
        tick(1, 0, 0, 0);
        repeat (10) tick(0, 0, 0, 1);
        checks++; if (TIMEOUT_ERR_OUT !== 1'b1 || SYSCALL_COUNT_OUT !== 16'd2) begin
            failures++; $display("FAIL wdog_sticky got_err=%b got_cnt=%0d exp=1/2", TIMEOUT_ERR_OUT, SYSCALL_COUNT_OUT);
        end
`else
        for (int i = 0; i < 300; i++) begin
            tick(0, 0, 0, 0);
            if (SYS_OUT) sys++;
        end
        checks++; if (sys != 300 - DRAIN) begin failures++; $display("FAIL nowdog_wait got=%0d exp=%0d", sys, 300 - DRAIN); end
        checks++; if (TIMEOUT_ERR_OUT !== 1'b0) begin failures++; $display("FAIL nowdog_err got=%b exp=0", TIMEOUT_ERR_OUT); end
        tick(0, 0, 0, 1);
        tick(0, 0, 0, 0);
        checks++; if (SYSCALL_COUNT_OUT !== 16'd1) begin failures++; $display("FAIL nowdog_count got=%0d exp=1", SYSCALL_COUNT_OUT); end
`endif
    endtask

    // Random traffic checked cycle by cycle against the reference model.
    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            tick($urandom_range(99) < 30, $urandom_range(99) < 30,
                 $urandom_range(99) < 20, $urandom_range(99) < 25);
            checks++;
            if (got_vec !== exp_vec) begin
                failures++;
                $display("FAIL random cyc=%0d got=%h exp=%h", i, got_vec, exp_vec);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_syscall();
        test_llsc();
        test_freeze_mid_drain();
        test_reset_mid_service();
        test_back_to_back();
        test_idle_defer();
        test_watchdog();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stall_sequencer.md
STALL_SEQUENCER -- requirements
Module: stall_sequencer

Interface
REQ-001 Parameter DRAIN_CYCLES, default 3, number of bubble cycles inserted before a syscall is serviced (legal 1..7).
REQ-002 Parameter TIMEOUT_CYCLES, default 255, service watchdog limit (legal 1..255, used only under REQ-030).
REQ-003 CLK  in  1  the single clock for the block.
REQ-004 RESET  in  1  asynchronous, active-low reset.
REQ-005 SYSCALL_IN  in  1  decoded syscall or LL/SC-flush instruction present in ID this cycle.
REQ-006 LLSC_IN  in  1  qualifies SYSCALL_IN as an LL/SC flush, which is not reported to the simulator.
REQ-007 MEM_FREEZE_IN  in  1  MEM stage requests a global stall.
REQ-008 SIM_ACK_IN  in  1  simulator has finished servicing the syscall.
REQ-009 FREEZE_IF_OUT  out  1  fetch holds its PC.
REQ-010 FREEZE_ID_OUT  out  1  ID holds its input instruction.
REQ-011 BUBBLE_ID_OUT  out  1  ID sends a NOP to EXE instead of the decoded instruction.
REQ-012 SYS_OUT  out  1  syscall service request to the simulator.
REQ-013 SYSCALL_COUNT_OUT  out  16  count of completed syscall services.
REQ-014 TIMEOUT_ERR_OUT  out  1  sticky watchdog error flag.

Function
REQ-015 The FSM SHALL have exactly four states, IDLE, DRAIN, SERVICE and RELEASE, with a free state encoding.
REQ-016 In IDLE, SYSCALL_IN=1 with MEM_FREEZE_IN=0 SHALL move to DRAIN and load the drain counter with DRAIN_CYCLES-1.
REQ-017 In DRAIN, the counter SHALL decrement each unfrozen cycle, and the FSM SHALL move to SERVICE on the cycle the counter is 0.
REQ-018 In SERVICE, the FSM SHALL move to RELEASE on SIM_ACK_IN=1, or on the next cycle without waiting when LLSC_IN=1 on SERVICE entry (latched).
REQ-019 RELEASE SHALL last exactly one cycle, SHALL ignore SYSCALL_IN, and SHALL then return to IDLE, so the same syscall is never retaken.
REQ-020 FREEZE_IF_OUT SHALL be combinational: MEM_FREEZE_IN | (IDLE & SYSCALL_IN) | DRAIN | SERVICE.
REQ-021 FREEZE_ID_OUT SHALL equal MEM_FREEZE_IN | DRAIN | SERVICE.
REQ-022 BUBBLE_ID_OUT SHALL be 1 exactly in DRAIN and SERVICE, giving DRAIN_CYCLES+service-length NOPs into EXE.
REQ-023 SYS_OUT SHALL be 1 exactly while the state is SERVICE and the latched LLSC flag is 0, decoded from the state register with no combinational input path.
REQ-024 MEM_FREEZE_IN=1 SHALL hold the state, the drain counter and the watchdog, and SHALL take precedence over every transition.
REQ-025 SIM_ACK_IN outside SERVICE SHALL be ignored.
REQ-026 SYSCALL_COUNT_OUT SHALL increment by 1 on every SERVICE->RELEASE transition, including LL/SC, and SHALL wrap from 0xFFFF to 0.
REQ-027 In IDLE, SYSCALL_IN and MEM_FREEZE_IN asserted together SHALL keep the FSM in IDLE, with DRAIN entry deferred until MEM_FREEZE_IN drops.

Reset
REQ-028 RESET=0 SHALL, at any time including mid-DRAIN or mid-SERVICE, force IDLE, counters 0, LLSC latch 0 and every registered output 0.
REQ-029 After reset release, the first SYSCALL_IN SHALL be accepted on the first clock edge.

Configuration
REQ-030 With STALL_SEQ_TIMEOUT_EN defined, the watchdog SHALL count SERVICE cycles; reaching TIMEOUT_CYCLES without SIM_ACK_IN SHALL force RELEASE and set TIMEOUT_ERR_OUT, which stays set until reset.
REQ-031 Without STALL_SEQ_TIMEOUT_EN, SERVICE SHALL wait indefinitely, TIMEOUT_ERR_OUT SHALL be tied to 0, and no watchdog register SHALL exist.

Verification
REQ-032 Syscall with DRAIN_CYCLES=3 and SIM_ACK_IN 2 cycles after SYS_OUT rises -> BUBBLE_ID_OUT high 5 cycles, SYS_OUT high 2 cycles, SYSCALL_COUNT_OUT=1, IDLE 2 cycles after ack.
REQ-033 Syscall with LLSC_IN=1 -> SYS_OUT never asserted, SERVICE lasts 1 cycle, SYSCALL_COUNT_OUT increments.
REQ-034 MEM_FREEZE_IN high 4 cycles mid-DRAIN -> drain counter frozen, total BUBBLE_ID_OUT cycles = 3+4+service-length, FREEZE_ID_OUT high throughout.
REQ-035 RESET pulsed low during SERVICE -> all outputs 0 asynchronously, FSM in IDLE, SYSCALL_COUNT_OUT=0.
REQ-036 SYSCALL_IN held high through RELEASE -> exactly one service, then a new DRAIN starts the cycle after returning to IDLE.
REQ-037 Under STALL_SEQ_TIMEOUT_EN with TIMEOUT_CYCLES=8 and no ack -> RELEASE after 8 SERVICE cycles, TIMEOUT_ERR_OUT=1 and sticky.
